// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, queue entry type and rd classification for the writeback unit.
package wb_pkg;
  localparam int WB_REG_ADDR_WIDTH = 5;
  localparam int WB_DEPTH = 2;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [WB_REG_ADDR_WIDTH-1:0] rd;
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] instruction;
  } wb_entry_t;
  function automatic logic is_silent(input logic [WB_REG_ADDR_WIDTH-1:0] rd);
    return rd == '0;
  endfunction
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: in-order circular result buffer with a youngest-entry read port.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic [WB_REG_ADDR_WIDTH-1:0] yng_rd,
  output logic [DATA_WIDTH-1:0] yng_result,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  // Storage is deliberately left unreset; outputs that read it are qualified by count.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  assign head = mem[rd_ptr];
  assign yng_rd = mem[wr_ptr - 1'b1].rd;
  assign yng_result = mem[wr_ptr - 1'b1].result;
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: queues execution results and drains them into the register-file write port.
// Optional WB_RETIRE_COUNT_EN adds a 32-bit retire_count output.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic uop_valid_in,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [INST_WIDTH-1:0] instruction_in,
  input  logic rf_wr_ready,
  output logic rf_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic stall_to_exe,
  output logic fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [INST_WIDTH-1:0] instruction_out,
  output logic retire_valid,
  output logic wb_overflow
`ifdef WB_RETIRE_COUNT_EN
  , output logic [31:0] retire_count
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic push, pop, full, empty;
  logic [CW-1:0] count;
  wb_entry_t head;
  logic [REG_ADDR_WIDTH-1:0] yng_rd;
  logic [DATA_WIDTH-1:0] yng_result;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [INST_WIDTH-1:0] inst_q;
  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din('{result: result_in, rd: rd_in, pc: pc_in, instruction: instruction_in}),
    .head(head), .yng_rd(yng_rd), .yng_result(yng_result),
    .full(full), .empty(empty), .count(count)
  );
  assign pop = !empty && (is_silent(head.rd) || rf_wr_ready);
  assign push = uop_valid_in && (!full || pop);
  assign rf_wr_en = !empty && !is_silent(head.rd);
  assign rf_wr_addr = rf_wr_en ? head.rd : '0;
  assign rf_wr_data = rf_wr_en ? head.result : '0;
  // One slot stays free for the uop already in the execution stage's second stage.
  assign stall_to_exe = count >= CW'(DEPTH - 1);
  assign fwd_valid = !empty && !is_silent(yng_rd);
  assign fwd_rd = fwd_valid ? yng_rd : '0;
  assign fwd_data = fwd_valid ? yng_result : '0;
  assign retire_valid = pop;
  assign pc_out = pop ? head.pc : pc_q;
  assign instruction_out = pop ? head.instruction : inst_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wb_overflow <= 1'b0;
      pc_q <= '0;
      inst_q <= '0;
    end else begin
      if (uop_valid_in && full && !pop) wb_overflow <= 1'b1;
      if (pop) begin
        pc_q <= head.pc;
        inst_q <= head.instruction;
      end
    end
`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) retire_count <= '0;
    else if (pop) retire_count <= retire_count + 32'd1;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard bench; the driver enqueues expected retirements, a negedge monitor checks them.
module tb_writeback_unit;
  localparam int DEPTH = 2;
  typedef struct {
    logic [4:0] rd;
    logic [31:0] d;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  logic clk = 1'b0, reset = 1'b1;
  logic uop_valid_in = 1'b0, rf_wr_ready = 1'b0;
  logic [31:0] result_in = '0, pc_in = '0, instruction_in = '0;
  logic [4:0] rd_in = '0;
  logic rf_wr_en, stall_to_exe, fwd_valid, retire_valid, wb_overflow;
  logic [4:0] rf_wr_addr, fwd_rd;
  logic [31:0] rf_wr_data, fwd_data, pc_out, instruction_out;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif
  ent_t sb[$];
  bit m_ovf = 1'b0;
  int unsigned m_retired = 0;
  logic [31:0] last_pc = '0, last_inst = '0, pc_ctr = 32'h200;
  int tests = 0, fails = 0;
  writeback_unit #(.DEPTH(DEPTH), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .uop_valid_in(uop_valid_in), .result_in(result_in),
    .rd_in(rd_in), .pc_in(pc_in), .instruction_in(instruction_in), .rf_wr_ready(rf_wr_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .stall_to_exe(stall_to_exe), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .pc_out(pc_out), .instruction_out(instruction_out), .retire_valid(retire_valid),
    .wb_overflow(wb_overflow)
`ifdef WB_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Monitor: compares DUT outputs to the queue model mid-cycle, consuming the head on an expected retire.
  always @(negedge clk) begin
    if (!reset) begin
      automatic bit has = sb.size() > 0;
      automatic bit exp_pop = has && (sb[0].rd == 0 || rf_wr_ready);
      chk("retire_valid", retire_valid, exp_pop);
      chk("rf_wr_en", rf_wr_en, has && sb[0].rd != 0);
      chk("stall_to_exe", stall_to_exe, sb.size() >= DEPTH - 1);
      chk("wb_overflow", wb_overflow, m_ovf);
      chk("fwd_valid", fwd_valid, has && sb[$].rd != 0);
      if (has && sb[$].rd != 0) begin
        chk("fwd_rd", fwd_rd, sb[$].rd);
        chk("fwd_data", fwd_data, sb[$].d);
      end
      if (has && sb[0].rd != 0) begin
        chk("rf_wr_addr", rf_wr_addr, sb[0].rd);
        chk("rf_wr_data", rf_wr_data, sb[0].d);
      end
`ifdef WB_RETIRE_COUNT_EN
      chk("retire_count", retire_count, m_retired);
`endif
      if (exp_pop) begin
        last_pc = sb[0].pc;
        last_inst = sb[0].inst;
        void'(sb.pop_front());
      end
      chk("pc_out", pc_out, last_pc);
      chk("instruction_out", instruction_out, last_inst);
    end
  end
  task automatic step(input bit v, input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc, input bit rdy);
    automatic ent_t e = '{rd: rd, d: d, pc: pc, inst: $urandom};
    automatic bit pop_e = sb.size() > 0 && (sb[0].rd == 0 || rdy);
    automatic bit push_e = v && (sb.size() < DEPTH || pop_e);
    automatic bit ovf_e = v && sb.size() == DEPTH && !pop_e;
    uop_valid_in = v; rd_in = rd; result_in = d; pc_in = pc; instruction_in = e.inst; rf_wr_ready = rdy;
    @(posedge clk);
    if (push_e) sb.push_back(e);
    if (ovf_e) m_ovf = 1'b1;
    if (pop_e) m_retired++;
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, " rf_wr_en"}, rf_wr_en, 1'b0);
    chk({tag, " fwd_valid"}, fwd_valid, 1'b0);
    chk({tag, " stall_to_exe"}, stall_to_exe, 1'b0);
    chk({tag, " retire_valid"}, retire_valid, 1'b0);
    chk({tag, " wb_overflow"}, wb_overflow, 1'b0);
    chk({tag, " pc_out"}, pc_out, 32'h0);
`ifdef WB_RETIRE_COUNT_EN
    chk({tag, " retire_count"}, retire_count, 32'h0);
`endif
  endtask
  task automatic mid_reset();
    uop_valid_in = 1'b0; rf_wr_ready = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid-reset");
    sb.delete(); m_ovf = 1'b0; m_retired = 0; last_pc = '0; last_inst = '0;
    #10 reset = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    #2 check_reset_outputs("reset");
    #11 reset = 1'b0;
    @(posedge clk); #1;
    step(1, 5, 32'h1234, 32'h100, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 32'hDEAD, 32'h104, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'h11, 32'h108, 0);
    step(1, 2, 32'h22, 32'h10C, 0);
    step(1, 4, 32'h44, 32'h110, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'h111, 32'h114, 0);
    step(1, 2, 32'h222, 32'h118, 0);
    step(1, 3, 32'h333, 32'h11C, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 7, 32'hA, 32'h120, 0);
    step(1, 9, 32'hB, 32'h124, 0);
    step(0, 0, 0, 0, 0);
    mid_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom, pc_ctr, $urandom_range(0, 2) != 0);
      pc_ctr += 4;
      if (i == 200) mid_reset();
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("queue drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage; consumer end of the execution-result interface.
- Accepts each valid result (result, destination register, PC, instruction) from the execution stage into a small in-order queue.
- Drains the queue into the register-file write port under a valid/ready handshake.
- Provides stall back-pressure to the execution stage and a youngest-entry forwarding tap for operand bypass.

Parameters:
DEPTH, 2, result queue entries; power of two, minimum 2
REG_ADDR_WIDTH, 5, register index width (x0..x31)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
uop_valid_in  input  1  execution result valid this cycle
result_in  input  DATA_WIDTH  execution result
rd_in  input  REG_ADDR_WIDTH  destination register
pc_in  input  ADDR_WIDTH  PC of the uop
instruction_in  input  INST_WIDTH  instruction word (sim/trace)
rf_wr_ready  input  1  register file accepts a write this cycle
rf_wr_en  output  1  register-file write request (valid)
rf_wr_addr  output  REG_ADDR_WIDTH  write address (head rd)
rf_wr_data  output  DATA_WIDTH  write data (head result)
stall_to_exe  output  1  execution stage must hold
fwd_valid  output  1  forwarding tap valid
fwd_rd  output  REG_ADDR_WIDTH  youngest queued rd
fwd_data  output  DATA_WIDTH  youngest queued result
pc_out  output  ADDR_WIDTH  PC of the entry retiring this cycle
instruction_out  output  INST_WIDTH  instruction of the entry retiring this cycle
retire_valid  output  1  one-cycle pulse per retired entry
wb_overflow  output  1  sticky: push attempted while full with no pop

Behaviour:
- Reset (async, active-high) clears wr_ptr, rd_ptr, count and wb_overflow; entry storage is not cleared.
  - All outputs are 0 during and after reset until the first push.
  - Assertion mid-operation discards all queued entries immediately; no write is issued.
- Storage: circular buffer with log2(DEPTH)-bit pointers wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - empty: count==0; full: count==DEPTH.
- Push: uop_valid_in && (!full || pop) writes the entry at wr_ptr on the clock edge and increments wr_ptr.
- Head classification:
  - Head with rd!=0 is "writing": rf_wr_en=1 with head rd/result.
  - Head with rd==0 is "silent": rf_wr_en=0.
- Pop (combinational): !empty && (silent || rf_wr_ready).
- Latency: a result pushed into an empty queue drives rf_wr_en in the next cycle. Minimum accept-to-write latency is 1 cycle.
- On pop, in the same cycle: retire_valid=1, pc_out/instruction_out = head fields.
  - Otherwise retire_valid=0; pc_out/instruction_out hold their last values.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full.
- Push while full with no pop: entry dropped, pointers unchanged, wb_overflow set to 1 until reset.
- stall_to_exe = (count >= DEPTH-1). This leaves one slot for the uop already in flight in the execution stage's second stage.
- Forwarding tap:
  - fwd_valid = !empty && youngest rd != 0.
  - Youngest entry is at wr_ptr-1 mod DEPTH; fwd_rd/fwd_data come from that entry.
  - The tap is combinational from storage and does not include the same-cycle input.
- rf_wr_en is never asserted when empty. Head fields are stable while rf_wr_en=1 && !rf_wr_ready.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- When defined: adds output retire_count (32 bits), reset to 0, incremented by 1 on each cycle with retire_valid=1, wrapping at 2^32.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package wb_pkg:
  - REG_ADDR_WIDTH constant and DEPTH default.
  - wb_entry_t struct {result, rd, pc, instruction}.
  - Function is_silent(rd) returning rd==0.
- One sub-module, wb_result_fifo: parameterized circular buffer with push/pop/full/empty/count and a youngest-entry read port.
- Top level holds pop logic, stall, overflow flag, retire outputs and the optional counter.

Test Plan:
- Reset then single push {rd=5, result=0x0000_1234, pc=0x100}, rf_wr_ready=1 -> next cycle rf_wr_en=1, addr=5, data=0x1234, retire_valid=1, pc_out=0x100; count returns to 0.
- Push rd=0 result=0xDEAD with rf_wr_ready=0 -> rf_wr_en stays 0, entry retires next cycle (retire_valid=1), no write issued.
- rf_wr_ready=0, push rd=1, rd=2 on consecutive cycles (DEPTH=2):
  - stall_to_exe=1 after the first push; full after the second.
  - Third push -> dropped, wb_overflow=1 sticky.
  - Raise rf_wr_ready -> writes rd=1 then rd=2 in order.
- Full queue, rf_wr_ready=1, simultaneous push rd=3 -> head rd=1 retires, rd=3 enqueued, count stays 2, no overflow; pointers wrap to 0 without loss.
- Push rd=7 data=0xA, then rd=9 data=0xB with rf_wr_ready=0 -> fwd_valid=1, fwd_rd=9, fwd_data=0xB. Assert reset asynchronously mid-cycle -> rf_wr_en, fwd_valid, stall_to_exe drop to 0 immediately.
- With WB_RETIRE_COUNT_EN: retire 5 entries (mix of rd=0 and rd!=0) -> retire_count=5; reset -> 0.
